mem_lsu: RTL
============

# mem_lsu

MEM-stage load/store unit of the five-stage MIPS pipeline, sitting directly downstream of the EX stage through the EX/MEM register. For each instruction it consumes the EX outputs: destination, write enable, ALU result, ALU op, effective address and store data. Non-memory ops pass straight through combinationally. Loads and stores run a multi-cycle request/acknowledge transaction on the data bus, with byte-lane steering, sign/zero extension, alignment checking and a timeout watchdog. While a transaction is pending it asserts a stall request to the pipeline controller.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles in BUS state without bus_ack_i before the access is aborted (range 1..255).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- wd_i  in  5  destination register address from EX/MEM
- wreg_i  in  1  destination write enable from EX/MEM
- wdata_i  in  32  EX result, used for non-memory ops
- aluop_i  in  8  op code
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store data
- stall_i  in  1  pipeline held by another stage this cycle
- bus_rdata_i  in  32  read data, valid with bus_ack_i
- bus_ack_i  in  1  single-cycle transaction acknowledge
- bus_req_o  out  1  transaction request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word address {mem_addr_i[31:2],2'b00}
- bus_sel_o  out  4  byte enables; bit3 = bits 31:24
- bus_wdata_o  out  32  write data
- wd_o  out  5  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  32  to MEM/WB
- stallreq_o  out  1  stall request to controller
- align_err_o  out  1  one-cycle misalignment flag
- bus_err_o  out  1  one-cycle timeout flag

## Operation
- Op codes: LB 8'hE0, LH 8'hE1, LW 8'hE3, LBU 8'hE4, LHU 8'hE5, SB 8'hE8, SH 8'hE9, SW 8'hEB. All other codes are non-memory ops.
- Byte order is big-endian. Byte offset a = mem_addr_i[1:0]:
  - byte lane = 31-8a..24-8a
  - half lane: bits 31:16 when a[1]=0, otherwise bits 15:0.
- Store steering:
  - SB: wdata = {4{reg2_i[7:0]}}; sel = 4'b1000 >> a.
  - SH: wdata = {2{reg2_i[15:0]}}; sel = 1100 when a[1]=0, else 0011.
  - SW: wdata = reg2_i; sel = 1111.
  - Load sel uses the same patterns by width.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW uses the word unchanged.
- Misalignment: LH/LHU/SH with a[0]=1, or LW/SW with a!=0. No bus access is made.
- FSM states IDLE, BUS, DONE; count register cnt is 8 bits.
  - IDLE, non-memory op: wd_o/wreg_o/wdata_o = inputs; stallreq_o = 0.
  - IDLE, memory op, aligned: stallreq_o = 1; next state BUS; cnt = 0.
  - IDLE, memory op, misaligned: align_err_o = 1, wreg_o = 0, stallreq_o = 0; stay IDLE.
  - BUS: bus_req_o = 1, stallreq_o = 1; we/addr/sel/wdata driven from the inputs, which the controller holds stable.
    - On bus_ack_i: capture bus_rdata_i into rdata_q; next state DONE.
    - Otherwise cnt increments. At cnt == TIMEOUT-1 with no ack: go to DONE with err_q = 1.
  - DONE: stallreq_o = 0; wd_o = wd_i.
    - Load without error: wreg_o = wreg_i, wdata_o = formatted rdata_q.
    - Store or error: wreg_o = 0, wdata_o = 0.
    - bus_err_o = err_q, asserted only in the first DONE cycle.
    - stall_i = 1 keeps the state in DONE; outputs stay stable. stall_i = 0 goes to IDLE and clears err_q.
- bus_ack_i outside BUS is ignored.

## Timing
- While rst = 1: every output is 0; state IDLE, cnt = 0, rdata_q = 0, err_q = 0.
- rst asserted in BUS or DONE aborts the access. bus_req_o falls in the cycle rst is high; after the edge the state is IDLE.
- Minimum memory-op latency is 3 cycles: IDLE → BUS (ack seen) → DONE. stallreq_o is high for the first 2 cycles.
- Each wait cycle without ack adds 1 cycle.
- Timeout: bus_req_o is high for exactly TIMEOUT cycles, then DONE.
- Ack arriving in the same cycle as cnt == TIMEOUT-1: the ack wins; no error.
- All bus outputs are 0 outside BUS.

## Test plan
- ADDU result 32'h1234 to wd 5, non-memory op → same cycle: wdata_o = 32'h1234, wreg_o = 1, stallreq_o = 0, bus_req_o = 0.
- LB at addr 0x101, ack in the first BUS cycle with rdata 32'h0080_0000 → sel 0100; DONE: wdata_o = 32'hFFFF_FF80; stallreq_o high for exactly 2 cycles.
- LHU at addr 0x102, rdata 32'hAAAA_8001, ack after 3 wait cycles → wdata_o = 32'h0000_8001; stallreq_o high for 5 cycles.
- SB reg2 = 32'h0000_00C3 at addr 0x7 → bus_we_o = 1, sel 0001, wdata 32'hC3C3_C3C3, addr 0x4; DONE: wreg_o = 0.
- LW at addr 0x6 → align_err_o pulses; no bus_req_o; wreg_o = 0; no stall.
- TIMEOUT = 4, SW with no ack → req high 4 cycles, then bus_err_o pulses for 1 cycle, wreg_o = 0. Repeat with rst asserted mid-BUS → IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/acknowledge data bus between the MEM-stage LSU and memory
interface mem_lsu_if;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   modport master(output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
                  input bus_rdata_i, bus_ack_i);
   modport slave(input bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
                 output bus_rdata_i, bus_ack_i);
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with lane steering, extension, alignment check and bus watchdog
module mem_lsu #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] reg2_i,
   input  logic        stall_i,
   mem_lsu_if.master   bus,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        stallreq_o,
   output logic        align_err_o,
   output logic        bus_err_o
);
   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic [31:0] rdata_q, rdata_n;
   logic        err_q, err_n, first_q, first_n;
   logic [1:0]  a;
   logic        is_load, is_store, is_mem, is_b, is_h, sgn, misal, ok;
   logic [3:0]  sel;
   logic [31:0] st_data, sh, ld_data;
   logic [15:0] half;
   assign a        = mem_addr_i[1:0];
   assign is_load  = aluop_i inside {8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5};
   assign is_store = aluop_i inside {8'hE8, 8'hE9, 8'hEB};
   assign is_mem   = is_load | is_store;
   assign is_b     = aluop_i inside {8'hE0, 8'hE4, 8'hE8};
   assign is_h     = aluop_i inside {8'hE1, 8'hE5, 8'hE9};
   assign sgn      = aluop_i inside {8'hE0, 8'hE1};
   assign misal    = is_mem & (is_h ? a[0] : (!is_b && a != 2'd0));
   assign sel      = is_b ? 4'b1000 >> a : is_h ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
   assign st_data  = is_b ? {4{reg2_i[7:0]}} : is_h ? {2{reg2_i[15:0]}} : reg2_i;
   // big-endian: byte at offset a lives in bits 31-8a..24-8a, so shift it down by 8*(3-a)
   assign sh       = rdata_q >> {~a, 3'b000};
   assign half     = a[1] ? rdata_q[15:0] : rdata_q[31:16];
   assign ld_data  = is_b ? {{24{sgn & sh[7]}}, sh[7:0]} :
                     is_h ? {{16{sgn & half[15]}}, half} : rdata_q;
   assign ok       = is_load & ~err_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         first_q <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         rdata_q <= rdata_n;
         err_q   <= err_n;
         first_q <= first_n;
      end
   end
   always_comb begin
      state_n         = state;
      cnt_n           = cnt;
      rdata_n         = rdata_q;
      err_n           = err_q;
      first_n         = 1'b0;
      bus.bus_req_o   = 1'b0;
      bus.bus_we_o    = 1'b0;
      bus.bus_addr_o  = 32'd0;
      bus.bus_sel_o   = 4'd0;
      bus.bus_wdata_o = 32'd0;
      wd_o            = 5'd0;
      wreg_o          = 1'b0;
      wdata_o         = 32'd0;
      stallreq_o      = 1'b0;
      align_err_o     = 1'b0;
      bus_err_o       = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (!is_mem) begin
                  wd_o    = wd_i;
                  wreg_o  = wreg_i;
                  wdata_o = wdata_i;
               end else if (misal) begin
                  wd_o        = wd_i;
                  align_err_o = 1'b1;
               end else begin
                  stallreq_o = 1'b1;
                  state_n    = BUS;
                  cnt_n      = 8'd0;
               end
            end
            BUS: begin
               bus.bus_req_o   = 1'b1;
               bus.bus_we_o    = is_store;
               bus.bus_addr_o  = {mem_addr_i[31:2], 2'b00};
               bus.bus_sel_o   = sel;
               bus.bus_wdata_o = is_store ? st_data : 32'd0;
               stallreq_o      = 1'b1;
               if (bus.bus_ack_i) begin
                  rdata_n = bus.bus_rdata_i;
                  state_n = DONE;
                  first_n = 1'b1;
               end else if (cnt == 8'(TIMEOUT - 1)) begin
                  err_n   = 1'b1;
                  state_n = DONE;
                  first_n = 1'b1;
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
            DONE: begin
               wd_o      = wd_i;
               wreg_o    = ok & wreg_i;
               wdata_o   = ok ? ld_data : 32'd0;
               bus_err_o = err_q & first_q;
               if (!stall_i) begin
                  state_n = IDLE;
                  err_n   = 1'b0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end
endmodule
